// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-port arbiter: size codes, port IDs,
// FSM state encodings and the access alignment rule.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b11;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b00;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_DONE   = 2'b11
  } arbState_e;

  // Word needs a 4-byte boundary, halfword a 2-byte boundary; code 10 is never legal.
  function automatic logic isAligned(input logic [1:0] addrLow, input logic [1:0] size);
    logic ok;
    case (size)
      SIZE_WORD: ok = (addrLow == 2'b00);
      SIZE_HALF: ok = (addrLow[0] == 1'b0);
      SIZE_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-requester alternating-priority grant. reqs[0] is fetch, reqs[1] is data.
// On a tie the requester that was not granted last wins.
module rr_grant2
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] reqs,
  input  logic       lastGrant,
  output logic [1:0] grant,
  output logic       valid
);

  // Pick a single winner; alternate on simultaneous requests.
  always_comb begin
    grant = 2'b00;
    case (reqs)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (lastGrant == PORT_IF) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
    valid = |reqs;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the RAM level handshake between instruction fetch and data memory.
// Every RAM-side signal is registered and memFuncActive always returns low
// between transactions so the RAM sees a fresh activation edge per access.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
)(
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifDone,
  output logic [DATA_W-1:0] ifData,
  output logic              ifError,
  input  logic              dmReq,
  input  logic              dmReadWrite,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmDataIn,
  input  logic [1:0]        dmDataSize,
  output logic              dmDone,
  output logic [DATA_W-1:0] dmDataOut,
  output logic              dmError,
  output logic              memFuncActive,
  output logic              readWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  output logic [1:0]        dataSize,
  input  logic              memFuncComplete,
  input  logic [DATA_W-1:0] dataOut,
  output logic              busy
);

  localparam logic [DATA_W-1:0] MASK_BYTE = {{(DATA_W-8){1'b0}}, 8'hFF};
  localparam logic [DATA_W-1:0] MASK_HALF = {{(DATA_W-16){1'b0}}, 16'hFFFF};
  localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);

  arbState_e         state_r, nextState_s;
  logic              lastGrant_r, lastGrant_s;
  logic              port_r, port_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [1:0]        size_r, size_s;
  logic              rw_r, rw_s;
  logic [7:0]        tmoCnt_r, tmoCnt_s;
  logic              memFuncActive_r, memFuncActive_s;
  logic              readWrite_r, readWrite_s;
  logic [ADDR_W-1:0] address_r, address_s;
  logic [DATA_W-1:0] dataIn_r, dataIn_s;
  logic [1:0]        dataSize_r, dataSize_s;
  logic              ifDone_r, ifDone_s, ifError_r, ifError_s;
  logic              dmDone_r, dmDone_s, dmError_r, dmError_s;
  logic [DATA_W-1:0] ifData_r, ifData_s, dmDataOut_r, dmDataOut_s;
  logic              busy_r, busy_s;
  logic [1:0]        grant_s;
  logic              grantValid_s;
  logic              finish_s, errFlag_s;
  logic [DATA_W-1:0] readMask_s, readData_s;

  rr_grant2 uGrant (
    .reqs      ({dmReq, ifReq}),
    .lastGrant (lastGrant_r),
    .grant     (grant_s),
    .valid     (grantValid_s)
  );

  // Zero-extend the RAM read data according to the latched access size.
  always_comb begin
    readMask_s = {DATA_W{1'b1}};
    case (size_r)
      SIZE_BYTE: readMask_s = MASK_BYTE;
      SIZE_HALF: readMask_s = MASK_HALF;
      default:   readMask_s = {DATA_W{1'b1}};
    endcase
    readData_s = dataOut & readMask_s;
  end

  // Next-state and next-register logic; outputs are computed for the state being entered.
  always_comb begin
    nextState_s     = state_r;
    lastGrant_s     = lastGrant_r;
    port_s          = port_r;
    addr_s          = addr_r;
    wdata_s         = wdata_r;
    size_s          = size_r;
    rw_s            = rw_r;
    tmoCnt_s        = tmoCnt_r;
    memFuncActive_s = memFuncActive_r;
    readWrite_s     = readWrite_r;
    address_s       = address_r;
    dataIn_s        = dataIn_r;
    dataSize_s      = dataSize_r;
    ifData_s        = ifData_r;
    dmDataOut_s     = dmDataOut_r;
    finish_s        = 1'b0;
    errFlag_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (grantValid_s) begin
          nextState_s = ST_CHECK;
          if (grant_s == 2'b10) begin
            port_s  = PORT_DM;
            addr_s  = dmAddr;
            wdata_s = dmDataIn;
            size_s  = dmDataSize;
            rw_s    = dmReadWrite;
          end else begin
            port_s  = PORT_IF;
            addr_s  = ifAddr;
            wdata_s = {DATA_W{1'b0}};
            size_s  = SIZE_WORD;
            rw_s    = 1'b0;
          end
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!isAligned(addr_r[1:0], size_r)) begin
          nextState_s = ST_DONE;
          finish_s    = 1'b1;
          errFlag_s   = 1'b1;
        end else begin
          nextState_s     = ST_ACTIVE;
          address_s       = addr_r;
          dataIn_s        = wdata_r;
          dataSize_s      = size_r;
          readWrite_s     = rw_r;
          memFuncActive_s = 1'b1;
          tmoCnt_s        = 8'd0;
        end
      end
      ST_ACTIVE: begin
        if (memFuncComplete) begin
          nextState_s     = ST_DONE;
          memFuncActive_s = 1'b0;
          finish_s        = 1'b1;
          if (!rw_r) begin
            if (port_r == PORT_IF) begin
              ifData_s = readData_s;
            end else begin
              dmDataOut_s = readData_s;
            end
          end else begin
            ifData_s = ifData_r;
          end
        end else if (tmoCnt_r == TMO_LAST) begin
          nextState_s     = ST_DONE;
          memFuncActive_s = 1'b0;
          finish_s        = 1'b1;
          errFlag_s       = 1'b1;
          if (port_r == PORT_IF) begin
            ifData_s = {DATA_W{1'b0}};
          end else begin
            dmDataOut_s = {DATA_W{1'b0}};
          end
        end else begin
          tmoCnt_s = tmoCnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        nextState_s = ST_IDLE;
        lastGrant_s = port_r;
      end
      default: begin
        nextState_s     = ST_IDLE;
        memFuncActive_s = 1'b0;
      end
    endcase

    ifDone_s  = finish_s && (port_r == PORT_IF);
    ifError_s = errFlag_s && (port_r == PORT_IF);
    dmDone_s  = finish_s && (port_r == PORT_DM);
    dmError_s = errFlag_s && (port_r == PORT_DM);
    busy_s    = (nextState_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Latched request, timeout counter and all registered outputs.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      lastGrant_r     <= PORT_IF;
      port_r          <= PORT_IF;
      addr_r          <= {ADDR_W{1'b0}};
      wdata_r         <= {DATA_W{1'b0}};
      size_r          <= 2'b00;
      rw_r            <= 1'b0;
      tmoCnt_r        <= 8'd0;
      memFuncActive_r <= 1'b0;
      readWrite_r     <= 1'b0;
      address_r       <= {ADDR_W{1'b0}};
      dataIn_r        <= {DATA_W{1'b0}};
      dataSize_r      <= 2'b00;
      ifDone_r        <= 1'b0;
      ifError_r       <= 1'b0;
      dmDone_r        <= 1'b0;
      dmError_r       <= 1'b0;
      ifData_r        <= {DATA_W{1'b0}};
      dmDataOut_r     <= {DATA_W{1'b0}};
      busy_r          <= 1'b0;
    end else begin
      lastGrant_r     <= lastGrant_s;
      port_r          <= port_s;
      addr_r          <= addr_s;
      wdata_r         <= wdata_s;
      size_r          <= size_s;
      rw_r            <= rw_s;
      tmoCnt_r        <= tmoCnt_s;
      memFuncActive_r <= memFuncActive_s;
      readWrite_r     <= readWrite_s;
      address_r       <= address_s;
      dataIn_r        <= dataIn_s;
      dataSize_r      <= dataSize_s;
      ifDone_r        <= ifDone_s;
      ifError_r       <= ifError_s;
      dmDone_r        <= dmDone_s;
      dmError_r       <= dmError_s;
      ifData_r        <= ifData_s;
      dmDataOut_r     <= dmDataOut_s;
      busy_r          <= busy_s;
    end
  end

  assign memFuncActive = memFuncActive_r;
  assign readWrite     = readWrite_r;
  assign address       = address_r;
  assign dataIn        = dataIn_r;
  assign dataSize      = dataSize_r;
  assign ifDone        = ifDone_r;
  assign ifError       = ifError_r;
  assign ifData        = ifData_r;
  assign dmDone        = dmDone_r;
  assign dmError       = dmError_r;
  assign dmDataOut     = dmDataOut_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a big-endian 512x8 RAM model.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        ResetN;
  logic        ifReq;
  logic [8:0]  ifAddr;
  logic        ifDone;
  logic [31:0] ifData;
  logic        ifError;
  logic        dmReq;
  logic        dmReadWrite;
  logic [8:0]  dmAddr;
  logic [31:0] dmDataIn;
  logic [1:0]  dmDataSize;
  logic        dmDone;
  logic [31:0] dmDataOut;
  logic        dmError;
  logic        memFuncActive;
  logic        readWrite;
  logic [8:0]  address;
  logic [31:0] dataIn;
  logic [1:0]  dataSize;
  logic        memFuncComplete;
  logic [31:0] dataOut;
  logic        busy;

  int passCnt  = 0;
  int totalCnt = 0;
  bit ramStall = 1'b0;

  logic [7:0] mem [0:511] = '{2: 8'h08, 3: 8'h21, default: 8'h00};

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifDone(ifDone), .ifData(ifData), .ifError(ifError),
    .dmReq(dmReq), .dmReadWrite(dmReadWrite), .dmAddr(dmAddr), .dmDataIn(dmDataIn),
    .dmDataSize(dmDataSize), .dmDone(dmDone), .dmDataOut(dmDataOut), .dmError(dmError),
    .memFuncActive(memFuncActive), .readWrite(readWrite), .address(address),
    .dataIn(dataIn), .dataSize(dataSize), .memFuncComplete(memFuncComplete),
    .dataOut(dataOut), .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // RAM read path: level handshake, data right-justified.
  always_comb begin
    logic [8:0] a1, a2, a3;
    a1 = address + 9'd1;
    a2 = address + 9'd2;
    a3 = address + 9'd3;
    memFuncComplete = memFuncActive && !ramStall;
    dataOut = 32'h0;
    case (dataSize)
      2'b11:   dataOut = {mem[address], mem[a1], mem[a2], mem[a3]};
      2'b01:   dataOut = {16'h0, mem[address], mem[a1]};
      2'b00:   dataOut = {24'h0, mem[address]};
      default: dataOut = 32'h0;
    endcase
  end

  // RAM write path: one write per completed write activation.
  always @(posedge Clk) begin
    if (memFuncActive && readWrite && memFuncComplete) begin
      case (dataSize)
        2'b11: begin
          mem[address]        <= dataIn[31:24];
          mem[address + 9'd1] <= dataIn[23:16];
          mem[address + 9'd2] <= dataIn[15:8];
          mem[address + 9'd3] <= dataIn[7:0];
        end
        2'b01: begin
          mem[address]        <= dataIn[15:8];
          mem[address + 9'd1] <= dataIn[7:0];
        end
        2'b00: mem[address] <= dataIn[7:0];
        default: ;
      endcase
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on one port; returns data, error, cycles to Done and ACTIVE cycles.
  task automatic doTxn(input string name, input bit isDm, input logic rw, input logic [8:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size,
                       output logic [31:0] rdata, output logic err, output int lat, output int act);
    bit   got;
    int   cyc;
    logic busySeen, actAtDone;
    got = 1'b0; cyc = 0; act = 0; rdata = 32'h0; err = 1'b0; busySeen = 1'b0; actAtDone = 1'b1;
    @(negedge Clk);
    if (isDm) begin
      dmReq = 1'b1; dmReadWrite = rw; dmAddr = addr; dmDataIn = wdata; dmDataSize = size;
    end else begin
      ifReq = 1'b1; ifAddr = addr;
    end
    while (!got && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) busySeen = busy;
      if (memFuncActive) act++;
      if (isDm ? dmDone : ifDone) begin
        got       = 1'b1;
        rdata     = isDm ? dmDataOut : ifData;
        err       = isDm ? dmError : ifError;
        actAtDone = memFuncActive;
      end
    end
    ifReq = 1'b0;
    dmReq = 1'b0;
    lat = cyc;
    checkEq({name, "_done_seen"}, 32'(got), 32'd1);
    checkEq({name, "_busy_in_check"}, 32'(busySeen), 32'd1);
    checkEq({name, "_active_low_at_done"}, 32'(actAtDone), 32'd0);
    @(negedge Clk);
    checkEq({name, "_single_done"}, {30'h0, ifDone, dmDone}, 32'd0);
    checkEq({name, "_idle_active_low"}, 32'(memFuncActive), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, ifD, dmD;
    logic        er;
    int          lat, act, nDone, cyc, both;
    logic [3:0]  order;
    bit          seen;

    ResetN = 1'b0; ifReq = 1'b0; ifAddr = 9'd0; dmReq = 1'b0; dmReadWrite = 1'b0;
    dmAddr = 9'd0; dmDataIn = 32'h0; dmDataSize = 2'b00;
    repeat (3) @(negedge Clk);
    checkEq("rst_ctrl_bits", {25'h0, memFuncActive, readWrite, ifDone, ifError, dmDone, dmError, busy}, 32'd0);
    checkEq("rst_address", {23'h0, address}, 32'd0);
    checkEq("rst_dataIn", dataIn, 32'd0);
    checkEq("rst_dataSize", {30'h0, dataSize}, 32'd0);
    checkEq("rst_ifData", ifData, 32'd0);
    checkEq("rst_dmDataOut", dmDataOut, 32'd0);
    ResetN = 1'b1;

    // Fetch of the preloaded word at 0.
    doTxn("if0", 1'b0, 1'b0, 9'd0, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("if0_data", rd, 32'h00000821);
    checkEq("if0_err", 32'(er), 32'd0);
    checkEq("if0_latency", 32'(lat), 32'd3);
    checkEq("if0_active_cycles", 32'(act), 32'd1);

    // Word write then word read at 40.
    doTxn("wr40", 1'b1, 1'b1, 9'd40, 32'hDEADBEEF, 2'b11, rd, er, lat, act);
    checkEq("wr40_err", 32'(er), 32'd0);
    checkEq("wr40_ram_bytes", {mem[40], mem[41], mem[42], mem[43]}, 32'hDEADBEEF);
    doTxn("rd40", 1'b1, 1'b0, 9'd40, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("rd40_data", rd, 32'hDEADBEEF);
    checkEq("rd40_latency", 32'(lat), 32'd3);

    // Halfword and byte reads.
    doTxn("rdh42", 1'b1, 1'b0, 9'd42, 32'h0, 2'b01, rd, er, lat, act);
    checkEq("rdh42_data", rd, 32'h0000BEEF);
    doTxn("rdb43", 1'b1, 1'b0, 9'd43, 32'h0, 2'b00, rd, er, lat, act);
    checkEq("rdb43_data", rd, 32'h000000EF);

    // Halfword write placement and a word at the top of memory.
    doTxn("wrh44", 1'b1, 1'b1, 9'd44, 32'h0000CAFE, 2'b01, rd, er, lat, act);
    doTxn("rd44", 1'b1, 1'b0, 9'd44, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("rd44_data", rd, 32'hCAFE0000);
    doTxn("wr508", 1'b1, 1'b1, 9'd508, 32'h11223344, 2'b11, rd, er, lat, act);
    checkEq("wr508_err", 32'(er), 32'd0);
    doTxn("rd508", 1'b1, 1'b0, 9'd508, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("rd508_data", rd, 32'h11223344);

    // Alignment violations never touch the RAM.
    doTxn("mis41w", 1'b1, 1'b0, 9'd41, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("mis41w_err", 32'(er), 32'd1);
    checkEq("mis41w_latency", 32'(lat), 32'd2);
    checkEq("mis41w_active", 32'(act), 32'd0);
    doTxn("mis41h", 1'b1, 1'b0, 9'd41, 32'h0, 2'b01, rd, er, lat, act);
    checkEq("mis41h_err", 32'(er), 32'd1);
    doTxn("size10", 1'b1, 1'b0, 9'd40, 32'h0, 2'b10, rd, er, lat, act);
    checkEq("size10_err", 32'(er), 32'd1);
    checkEq("size10_active", 32'(act), 32'd0);

    // RAM never completes: timeout error with zeroed data.
    ramStall = 1'b1;
    doTxn("tmo", 1'b1, 1'b0, 9'd40, 32'h0, 2'b11, rd, er, lat, act);
    checkEq("tmo_err", 32'(er), 32'd1);
    checkEq("tmo_data", rd, 32'h0);
    checkEq("tmo_active_cycles", 32'(act), 32'd15);
    checkEq("tmo_latency", 32'(lat), 32'd17);

    // Reset while ACTIVE abandons the access.
    @(negedge Clk);
    dmReq = 1'b1; dmReadWrite = 1'b0; dmAddr = 9'd40; dmDataSize = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk);
      if (memFuncActive) seen = 1'b1;
    end
    checkEq("rstmid_active_seen", 32'(seen), 32'd1);
    ResetN = 1'b0;
    dmReq = 1'b0;
    @(negedge Clk);
    checkEq("rstmid_active_drop", 32'(memFuncActive), 32'd0);
    checkEq("rstmid_busy_drop", 32'(busy), 32'd0);
    seen = dmDone;
    ResetN = 1'b1;
    ramStall = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (dmDone) seen = 1'b1;
    end
    checkEq("rstmid_no_done", 32'(seen), 32'd0);

    // Both held: strict alternation starting with DM.
    @(negedge Clk);
    dmReq = 1'b1; dmReadWrite = 1'b0; dmAddr = 9'd40; dmDataSize = 2'b11;
    ifReq = 1'b1; ifAddr = 9'd0;
    nDone = 0; cyc = 0; both = 0; order = 4'b0000; ifD = 32'h0; dmD = 32'h0;
    while (nDone < 4 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (ifDone && dmDone) both++;
      if (dmDone) begin
        order[nDone] = 1'b1; dmD = dmDataOut; nDone++;
      end else if (ifDone) begin
        order[nDone] = 1'b0; ifD = ifData; nDone++;
      end
      if (nDone == 4) begin
        ifReq = 1'b0; dmReq = 1'b0;
      end
    end
    ifReq = 1'b0; dmReq = 1'b0;
    checkEq("arb_done_count", 32'(nDone), 32'd4);
    checkEq("arb_order", {28'h0, order}, 32'h5);
    checkEq("arb_cycles", 32'(cyc), 32'd15);
    checkEq("arb_no_double_done", 32'(both), 32'd0);
    checkEq("arb_dm_data", dmD, 32'hDEADBEEF);
    checkEq("arb_if_data", ifD, 32'h00000821);
    @(negedge Clk);
    checkEq("arb_idle_after", {29'h0, ifDone, dmDone, busy}, 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the 512x8 byte-addressed RAM's level handshake (memFuncActive/readWrite in, memFuncComplete/dataOut back) and shares it between two requesters: instruction fetch (IF, read-only word) and data memory (DM, read/write, byte/halfword/word).
- Sits between the CPU control unit and the RAM.
- Registers all RAM-side outputs.
- Guarantees memFuncActive returns low between transactions, so every access produces a fresh activation edge at the RAM.
- Adds alignment checking and a completion timeout.

Parameters:
ADDR_W, 9, RAM byte-address width
DATA_W, 32, data bus width
TIMEOUT, 15, max ACTIVE cycles waiting for memFuncComplete before an error completion (1..255)

Ports:
Clk  in  1  system clock, rising edge
ResetN  in  1  synchronous active-low reset
ifReq  in  1  fetch request; level, held until ifDone
ifAddr  in  ADDR_W  fetch byte address
ifDone  out  1  one-cycle completion pulse
ifData  out  DATA_W  fetched word; valid while ifDone=1, held afterwards
ifError  out  1  qualifies ifDone: misaligned or timeout
dmReq  in  1  data request; level, held until dmDone
dmReadWrite  in  1  1=write, 0=read (RAM encoding)
dmAddr  in  ADDR_W  data byte address
dmDataIn  in  DATA_W  write data, right-justified for byte/halfword
dmDataSize  in  2  11 word, 01 halfword, 00 byte, 10 illegal
dmDone  out  1  one-cycle completion pulse
dmDataOut  out  DATA_W  read data, zero-extended; valid while dmDone=1
dmError  out  1  qualifies dmDone
memFuncActive  out  1  to RAM
readWrite  out  1  to RAM
address  out  ADDR_W  to RAM
dataIn  out  DATA_W  to RAM
dataSize  out  2  to RAM
memFuncComplete  in  1  from RAM
dataOut  in  DATA_W  from RAM
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (ResetN=0 at a rising edge):
  - State -> IDLE.
  - All outputs 0, including ifData/dmDataOut.
  - lastGrant = IF, so DM wins the first tie.
- Reset mid-transaction: memFuncActive drops the next cycle, the transaction is abandoned and no done pulse is issued.
- FSM states: IDLE, CHECK, ACTIVE, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one requester is pending, it is granted.
  - If both are pending, the requester not granted last wins (strict alternation).
  - On grant: latch the port ID, address, data, size and direction. IF is always read/word.
  - Go to CHECK.
- CHECK (1 cycle):
  - Alignment rules: word requires addr[1:0]=00; halfword requires addr[0]=0; size 10 is illegal.
  - Violation: set the error flag and go to DONE without touching the RAM.
  - Otherwise: drive address/dataIn/dataSize/readWrite, set memFuncActive=1, clear the timeout counter and go to ACTIVE.
- ACTIVE:
  - memFuncActive is held 1.
  - memFuncComplete is sampled every edge. When it is 1, capture dataOut into the granted port's data register (reads only; writes leave it unchanged) and go to DONE.
  - If the counter reaches TIMEOUT, set error, force the data register to 0 and go to DONE.
- DONE (1 cycle):
  - memFuncActive=0.
  - The granted port's Done=1, Error reflects the flag.
  - Update lastGrant.
  - Next state IDLE.
- Latency: request seen at IDLE edge t; memFuncActive high in cycles t+1..; with the RAM completing immediately, data is captured at edge t+2 and Done is high in cycle t+2..t+3. Minimum of 4 cycles per access, including at least 1 cycle with memFuncActive low.
- Requesters must deassert Req at the edge that ends their Done cycle. A still-high Req in IDLE is treated as a new request.
- If Req is dropped mid-transaction, the access still completes and Done still pulses.
- Address arithmetic is the RAM's concern; the arbiter performs no wrap check. A word at 508 is legal.
- Never drive memFuncActive and change readWrite/address in the same cycle: RAM-side registers only load in CHECK.

Decomposition:
- Package mem_ctrl_pkg holds:
  - Size codes SIZE_WORD=2'b11, SIZE_HALF=2'b01, SIZE_BYTE=2'b00.
  - Port IDs PORT_IF=0, PORT_DM=1.
  - FSM state encodings.
  - An alignment-check function.
- Sub-module rr_grant2: 2-input alternating-priority grant. Inputs: reqs, lastGrant. Outputs: grant one-hot, valid. Purely combinational; lastGrant stays in the parent.

Test Plan:
- RAM preloaded with 0x00000821 at 0; ifReq, ifAddr=0 -> memFuncActive high 1 cycle after grant, ifDone pulse 1 cycle, ifData=0x00000821, ifError=0.
- DM word write 0xDEADBEEF at 40, then word read at 40 -> RAM bytes 40..43 = DE AD BE EF; dmDataOut=0xDEADBEEF; memFuncActive low at least 1 cycle between the accesses.
- DM halfword read at 42 after the above -> dmDataOut=0x0000BEEF; byte read at 43 -> 0x000000EF.
- ifReq and dmReq held together for 4 transactions -> grant order DM, IF, DM, IF; each Done fires exactly once per grant.
- dmAddr=41 word, then dmDataSize=10 -> dmDone with dmError=1 in the cycle after CHECK; memFuncActive never asserted.
- memFuncComplete forced 0 -> dmDone with dmError=1 after TIMEOUT=15 ACTIVE cycles, dmDataOut=0; ResetN=0 during ACTIVE -> memFuncActive=0 and busy=0 next cycle, no Done pulse.
